// File: rtl/spi_ctrl_pkg.sv
// Shared types for the SPI transaction sequencer: controller states and transfer size.
package spi_ctrl_pkg;

  localparam int SPI_BITS = 8;
  localparam int CNT_W    = $clog2(SPI_BITS);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    READ1,
    READ2,
    DONE
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after last_grant, wrapping around.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GRANT_W = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] last_grant,
  output logic               valid,
  output logic [GRANT_W-1:0] grant
);

  logic [2*NUM_REQ-1:0] doubled;
  logic [NUM_REQ-1:0]   rotated;
  int                   pos;

  // Rotating the doubled vector puts the requester just after last_grant at bit 0.
  always_comb begin
    doubled = {req, req} >> (int'(last_grant) + 1);
    rotated = doubled[NUM_REQ-1:0];
    valid   = 1'b0;
    grant   = last_grant;
    pos     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!valid && rotated[k]) begin
        valid = 1'b1;
        pos   = int'(last_grant) + 1 + k;
        if (pos >= NUM_REQ) pos = pos - NUM_REQ;
        if (pos >= NUM_REQ) pos = pos - NUM_REQ;
        grant = GRANT_W'(pos);
      end
    end
  end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one spi_master byte engine among NUM_REQ requesters; sequences a full-duplex
// 8-bit transfer per grant and returns the received byte with a one-cycle ack.
module spi_txn_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 sclk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] wdata,
  output logic [NUM_REQ-1:0]   ack,
  output logic [7:0]           rdata,
  output logic                 busy,
  output logic [GRANT_W-1:0]   grant_id,
  output logic [NUM_REQ-1:0]   cs_n,
  output logic                 m_start,
  output logic                 m_load,
  output logic                 m_read,
  output logic [7:0]           m_data_in,
  input  logic [7:0]           m_data_out
);

  state_t             state;
  logic [CNT_W-1:0]   bitcnt;
  logic [GRANT_W-1:0] last_grant;
  logic               arb_valid;
  logic [GRANT_W-1:0] arb_grant;
  logic [7:0]         sel_byte;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .GRANT_W (GRANT_W)
  ) u_rr (
    .req        (req),
    .last_grant (last_grant),
    .valid      (arb_valid),
    .grant      (arb_grant)
  );

  always_comb begin
    sel_byte = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant == GRANT_W'(i)) sel_byte = wdata[8*i +: 8];
    end
  end

  // Every output is set on the transition into the state it belongs to, so outputs
  // stay registered and track the state with no combinational path from req.
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      bitcnt     <= '0;
      last_grant <= GRANT_W'(NUM_REQ - 1);
      grant_id   <= '0;
      ack        <= '0;
      rdata      <= 8'h00;
      busy       <= 1'b0;
      cs_n       <= '1;
      m_start    <= 1'b0;
      m_load     <= 1'b0;
      m_read     <= 1'b0;
      m_data_in  <= 8'h00;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            state     <= LOAD;
            grant_id  <= arb_grant;
            m_data_in <= sel_byte;
            busy      <= 1'b1;
            cs_n      <= ~(NUM_REQ'(1) << arb_grant);
            m_start   <= 1'b1;
            m_load    <= 1'b1;
          end
        end
        LOAD: begin
          state  <= SHIFT;
          bitcnt <= '0;
          m_load <= 1'b0;
        end
        SHIFT: begin
          bitcnt <= bitcnt + CNT_W'(1);
          if (bitcnt == CNT_W'(SPI_BITS - 1)) begin
            state  <= READ1;
            m_read <= 1'b1;
          end
        end
        READ1: begin
          state   <= READ2;
          m_start <= 1'b0;
        end
        READ2: begin
          state  <= DONE;
          rdata  <= m_data_out;
          m_read <= 1'b0;
          cs_n   <= '1;
          ack    <= NUM_REQ'(1) << grant_id;
        end
        DONE: begin
          state      <= IDLE;
          last_grant <= grant_id;
          busy       <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Self-checking bench: 4-requester arbiter driving a behavioural SPI master + loopback
// slave, plus a single-requester build checking back-to-back spacing.
module tb_spi_txn_arbiter;

  logic        sclk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  ack;
  logic [7:0]  rdata;
  logic        busy;
  logic [1:0]  grant_id;
  logic [3:0]  cs_n;
  logic        m_start, m_load, m_read;
  logic [7:0]  m_data_in, m_data_out;

  logic [0:0]  req1 = 1'b0;
  logic [7:0]  wdata1 = 8'h00;
  logic [0:0]  ack1, grant_id1, cs_n1;
  logic [7:0]  rdata1, m_data_in1;
  logic        busy1, m_start1, m_load1, m_read1;
  logic [7:0]  m_data_out1 = 8'hC6;

  always #5 sclk = ~sclk;

  spi_txn_arbiter #(.NUM_REQ(4)) dut (
    .sclk(sclk), .reset(reset), .req(req), .wdata(wdata), .ack(ack), .rdata(rdata),
    .busy(busy), .grant_id(grant_id), .cs_n(cs_n), .m_start(m_start), .m_load(m_load),
    .m_read(m_read), .m_data_in(m_data_in), .m_data_out(m_data_out)
  );

  spi_txn_arbiter #(.NUM_REQ(1)) dut1 (
    .sclk(sclk), .reset(reset), .req(req1), .wdata(wdata1), .ack(ack1), .rdata(rdata1),
    .busy(busy1), .grant_id(grant_id1), .cs_n(cs_n1), .m_start(m_start1), .m_load(m_load1),
    .m_read(m_read1), .m_data_in(m_data_in1), .m_data_out(m_data_out1)
  );

  // Behavioural spi_master with a loopback slave: LSB-first full-duplex exchange.
  logic [7:0] mshift = 8'h00, sshift = 8'h00, mdout = 8'h00, slave_byte = 8'h00;
  int         shift_cnt = 0;
  always @(posedge sclk) begin
    if (m_start && m_load) begin
      mshift    <= m_data_in;
      sshift    <= slave_byte;
      shift_cnt <= 0;
    end else if (m_start && !m_read) begin
      mshift    <= {sshift[0], mshift[7:1]};
      sshift    <= {mshift[0], sshift[7:1]};
      shift_cnt <= shift_cnt + 1;
    end
    if (m_start && m_read) mdout <= mshift;
  end
  assign m_data_out = mdout;

  // Protocol monitor: running totals, sampled away from the active edge.
  int         cs_low_total = 0, load_total = 0, ack_total = 0, ack_err = 0, overlap_err = 0;
  logic [3:0] prev_ack = 4'h0;
  always @(negedge sclk) begin
    if (reset) begin
      if (cs_n != 4'hF) cs_low_total <= cs_low_total + 1;
      if (m_load) load_total <= load_total + 1;
      if (ack != 4'h0) ack_total <= ack_total + 1;
      if (!$onehot0(ack) || (ack != 4'h0 && prev_ack != 4'h0)) ack_err <= ack_err + 1;
      if (!$onehot0(~cs_n)) overlap_err <= overlap_err + 1;
      prev_ack <= ack;
    end
  end

  typedef struct {
    bit          do_reset;
    logic [3:0]  req;
    logic [31:0] wd;
    logic [7:0]  slave;
    int          exp_id;
  } vec_t;

  vec_t vecs[12];
  int   tests = 0, fails = 0;
  int   cs_snap = 0, load_snap = 0, ack_snap = 0;
  int   id, cyc, model_last, got, idle_cnt, seen;
  logic [3:0]  rmask;
  logic [31:0] rwd;
  logic [7:0]  rslave;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [31:0] w, input logic [7:0] s);
    req        = r;
    wdata      = w;
    slave_byte = s;
    cs_snap    = cs_low_total;
    load_snap  = load_total;
  endtask

  task automatic waitAck(input int budget, output int ack_id, output int cycles);
    ack_id = -1;
    cycles = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge sclk);
      if (ack != 4'h0) begin
        cycles = c;
        for (int i = 0; i < 4; i++) if (ack == 4'(1 << i)) ack_id = i;
        break;
      end
    end
    if (cycles == 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL ack_timeout: got none, expected ack within %0d cycles", budget);
    end
  endtask

  task automatic checkTransfer(input string tag, input int got_id, input int exp_id,
                               input logic [31:0] w, input logic [7:0] s);
    checkOutput({tag, "_ack_id"}, got_id, exp_id);
    checkOutput({tag, "_grant_id"}, grant_id, exp_id);
    checkOutput({tag, "_rdata"}, rdata, s);
    checkOutput({tag, "_mosi_byte"}, sshift, 8'(w >> (8 * exp_id)));
    checkOutput({tag, "_shifts"}, shift_cnt, 8);
    checkOutput({tag, "_cs_at_ack"}, cs_n, 4'hF);
    checkOutput({tag, "_cs_low_cycles"}, cs_low_total - cs_snap, 11);
    checkOutput({tag, "_load_cycles"}, load_total - load_snap, 1);
  endtask

  // Round-robin rule: scan upward from the requester after the last one served.
  function automatic int pick(input logic [3:0] m, input int last);
    for (int k = 1; k <= 4; k++) if (m[2'((last + k) % 4)]) return (last + k) % 4;
    return -1;
  endfunction

  initial begin
    vecs[0]  = '{1'b1, 4'b0001, 32'h000000A5, 8'h3C, 0};
    vecs[1]  = '{1'b1, 4'b1111, 32'h44332211, 8'h81, 0};
    vecs[2]  = '{1'b0, 4'b1111, 32'h44332211, 8'h42, 1};
    vecs[3]  = '{1'b0, 4'b1111, 32'h44332211, 8'h24, 2};
    vecs[4]  = '{1'b0, 4'b1111, 32'h44332211, 8'hE7, 3};
    vecs[5]  = '{1'b0, 4'b1111, 32'h44332211, 8'h0F, 0};
    vecs[6]  = '{1'b0, 4'b0100, 32'h00C30000, 8'h5A, 2};
    vecs[7]  = '{1'b0, 4'b0101, 32'h006600B2, 8'h1D, 0};
    vecs[8]  = '{1'b0, 4'b0101, 32'h006600B2, 8'h9E, 2};
    vecs[9]  = '{1'b0, 4'b1000, 32'hD7000000, 8'h6B, 3};
    vecs[10] = '{1'b0, 4'b0011, 32'h0000F00D, 8'h01, 0};
    vecs[11] = '{1'b0, 4'b0011, 32'h0000F00D, 8'hFE, 1};

    repeat (2) @(negedge sclk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ack", ack, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_cs_n", cs_n, 4'hF);
    checkOutput("rst_grant_id", grant_id, 0);
    checkOutput("rst_master_ctl", {m_start, m_load, m_read}, 0);
    checkOutput("rst_data_in", m_data_in, 0);
    checkOutput("rst_n1_ctl", {m_start1, m_load1, m_read1, busy1, ack1}, 0);
    reset = 1'b1;
    @(negedge sclk);

    // Single-requester build: back-to-back transfers separated by one idle cycle.
    req1   = 1'b1;
    wdata1 = 8'h3B;
    for (int k = 0; k < 3; k++) begin
      got = 0;
      for (int c = 0; c < 40 && got == 0; c++) begin
        @(negedge sclk);
        if (ack1[0]) got = 1;
      end
      checkOutput("n1_ack", got, 1);
      checkOutput("n1_rdata", rdata1, 8'hC6);
      checkOutput("n1_grant", grant_id1, 0);
      checkOutput("n1_cs_at_ack", cs_n1, 1);
      if (k == 2) req1 = 1'b0;
      if (k < 2) begin
        idle_cnt = 0;
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
          @(negedge sclk);
          if (m_load1) seen = 1;
          else if (!busy1) idle_cnt++;
        end
        checkOutput("n1_idle_gap", idle_cnt, 1);
        checkOutput("n1_data_in", m_data_in1, 8'h3B);
      end
    end

    // Directed vector table: ack arrives in the 13th cycle counting the sampling IDLE
    // cycle as the first; one extra cycle when the request is raised during DONE.
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].do_reset) begin
        req = 4'h0;
        @(negedge sclk);
        reset = 1'b0;
        repeat (2) @(negedge sclk);
        reset = 1'b1;
        repeat (2) @(negedge sclk);
        model_last = 3;
      end
      applyStimulus(vecs[i].req, vecs[i].wd, vecs[i].slave);
      waitAck(40, id, cyc);
      checkOutput($sformatf("vec%0d_latency", i), cyc, vecs[i].do_reset ? 12 : 13);
      checkTransfer($sformatf("vec%0d", i), id, vecs[i].exp_id, vecs[i].wd, vecs[i].slave);
      model_last = vecs[i].exp_id;
    end

    // Reset in the middle of SHIFT (bit 4): immediate abort, no ack, clean restart.
    req = 4'h0;
    repeat (2) @(negedge sclk);
    applyStimulus(4'b0001, 32'h000000AB, 8'h11);
    repeat (6) @(negedge sclk);
    reset = 1'b0;
    #1;
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_cs_n", cs_n, 4'hF);
    checkOutput("midrst_ack", ack, 0);
    checkOutput("midrst_m_start", m_start, 0);
    req = 4'h0;
    repeat (3) @(negedge sclk);
    reset = 1'b1;
    ack_snap = ack_total;
    repeat (15) @(negedge sclk);
    checkOutput("midrst_no_ack", ack_total - ack_snap, 0);
    model_last = 3;
    applyStimulus(4'b0010, 32'h0000C300, 8'h7E);
    waitAck(40, id, cyc);
    checkTransfer("restart", id, 1, 32'h0000C300, 8'h7E);
    model_last = 1;

    // Request dropped and data changed mid-transfer: original byte still goes out.
    applyStimulus(4'b0001, 32'h0000005A, 8'h99);
    repeat (5) @(negedge sclk);
    req   = 4'h0;
    wdata = 32'h000000FF;
    waitAck(40, id, cyc);
    checkTransfer("dropreq", id, 0, 32'h0000005A, 8'h99);
    model_last = 0;

    // Randomized traffic against the round-robin reference model.
    for (int t = 0; t < 20; t++) begin
      rmask  = 4'($urandom_range(1, 15));
      rwd    = $urandom;
      rslave = 8'($urandom_range(0, 255));
      applyStimulus(rmask, rwd, rslave);
      waitAck(40, id, cyc);
      checkTransfer($sformatf("rand%0d", t), id, pick(rmask, model_last), rwd, rslave);
      model_last = pick(rmask, model_last);
    end
    req = 4'h0;
    repeat (3) @(negedge sclk);

    checkOutput("ack_protocol", ack_err, 0);
    checkOutput("cs_overlap", overlap_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
